// File: rtl/smem_dma_scheduler_pkg.sv
// Shared definitions for the SMEM DMA/IRQ scheduler and the downstream
// violation detector: default SMEM window, FSM state encodings and the
// last-word-address helper, so every consumer computes identical bounds.
package smem_dma_scheduler_pkg;

    // 2'd3 is unused; the FSM treats it as illegal and recovers to OPEN.
    typedef enum logic [1:0] {
        ST_OPEN    = 2'd0,
        ST_SECURE  = 2'd1,
        ST_GUARD   = 2'd2,
        ST_ILLEGAL = 2'd3
    } smem_state_e;

    localparam logic [15:0] SMEM_BASE_DEF  = 16'hA000;
    localparam logic [15:0] SMEM_SIZE_DEF  = 16'h4000;
    localparam logic [3:0]  EXIT_GUARD_DEF = 4'd4;
    localparam logic [15:0] MAX_DEFER_DEF  = 16'd1024;

    // Last word address inside SMEM (size is in bytes, words are 2 bytes).
    function automatic logic [15:0] last_smem_addr(input logic [15:0] base,
                                                   input logic [15:0] size);
        return base + size - 16'd2;
    endfunction

endpackage

// File: rtl/smem_range_cmp.sv
// smem_range_cmp: combinational "PC is inside SMEM" decode.
// Shared with the violation detector so both blocks use the same bounds.
// Ports:
//   pc      in  16  current core PC
//   in_smem out 1   pc lies in [SMEM_BASE, last SMEM word]
module smem_range_cmp
    import smem_dma_scheduler_pkg::*;
#(
    parameter logic [15:0] SMEM_BASE = SMEM_BASE_DEF,
    parameter logic [15:0] SMEM_SIZE = SMEM_SIZE_DEF
) (
    input  logic [15:0] pc,
    output logic        in_smem
);

    localparam logic [15:0] LAST_SMEM_ADDR = last_smem_addr(SMEM_BASE, SMEM_SIZE);

    assign in_smem = (pc >= SMEM_BASE) && (pc <= LAST_SMEM_ADDR);

endmodule

// File: rtl/smem_dma_scheduler.sv
// smem_dma_scheduler: holds off DMA grants and masks IRQs while the core
// executes from secure ROM (SMEM) and for a guard window after it leaves,
// so the downstream DMA/IRQ violation detector never fires a kill-reset.
// Optional feature macro: IRQ_DEFER_EN (latch masked IRQs and deliver them
// in the first OPEN cycle). Without it masked IRQs are dropped.
// Ports:
//   clk          in   1   system clock
//   reset_n      in   1   synchronous reset, active-low
//   pc           in   16  current core PC
//   dma_req      in   1   DMA controller requests the bus
//   dma_grant    out  1   bus granted to DMA (combinational, zero latency)
//   irq_in       in   1   raw interrupt request
//   irq_ack      in   1   core acknowledges the serviced IRQ
//   irq_out      out  1   interrupt presented to the core
//   secure_busy  out  1   registered: state != OPEN
//   defer_ovf    out  1   sticky: a DMA request waited MAX_DEFER cycles
module smem_dma_scheduler
    import smem_dma_scheduler_pkg::*;
#(
    parameter logic [15:0] SMEM_BASE  = SMEM_BASE_DEF,
    parameter logic [15:0] SMEM_SIZE  = SMEM_SIZE_DEF,
    parameter logic [3:0]  EXIT_GUARD = EXIT_GUARD_DEF,
    parameter logic [15:0] MAX_DEFER  = MAX_DEFER_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] pc,
    input  logic        dma_req,
    output logic        dma_grant,
    input  logic        irq_in,
    input  logic        irq_ack,
    output logic        irq_out,
    output logic        secure_busy,
    output logic        defer_ovf
);

    smem_state_e state_r, state_next_s;
    logic [3:0]  guard_cnt_r, guard_next_s;
    logic [15:0] wait_cnt_r, wait_next_s;
    logic        secure_busy_r;
    logic        defer_ovf_r;
    logic        in_smem_s;
    logic        open_s;

    smem_range_cmp #(
        .SMEM_BASE (SMEM_BASE),
        .SMEM_SIZE (SMEM_SIZE)
    ) u_range (
        .pc      (pc),
        .in_smem (in_smem_s)
    );

    // Access is allowed only in OPEN and not on the cycle the PC enters SMEM.
    assign open_s    = (state_r == ST_OPEN) && !in_smem_s;
    assign dma_grant = dma_req && open_s;

    // Next-state and guard counter; re-entry takes priority over guard expiry.
    always_comb begin
        state_next_s = state_r;
        guard_next_s = guard_cnt_r;
        case (state_r)
            ST_OPEN: begin
                if (in_smem_s) begin
                    state_next_s = ST_SECURE;
                end else begin
                    state_next_s = ST_OPEN;
                end
            end
            ST_SECURE: begin
                if (!in_smem_s) begin
                    state_next_s = ST_GUARD;
                    guard_next_s = EXIT_GUARD - 4'd1;
                end else begin
                    state_next_s = ST_SECURE;
                end
            end
            ST_GUARD: begin
                if (in_smem_s) begin
                    state_next_s = ST_SECURE;
                end else if (guard_cnt_r == 4'd0) begin
                    state_next_s = ST_OPEN;
                end else begin
                    guard_next_s = guard_cnt_r - 4'd1;
                end
            end
            default: begin
                state_next_s = ST_OPEN;
                guard_next_s = 4'd0;
            end
        endcase
    end

    // DMA wait counter: counts denied request cycles, saturating.
    always_comb begin
        if (!dma_req || dma_grant) begin
            wait_next_s = 16'd0;
        end else if (wait_cnt_r == 16'hFFFF) begin
            wait_next_s = 16'hFFFF;
        end else begin
            wait_next_s = wait_cnt_r + 16'd1;
        end
    end

    // FSM, counters, busy flag and sticky overflow registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r       <= ST_OPEN;
            guard_cnt_r   <= 4'd0;
            wait_cnt_r    <= 16'd0;
            secure_busy_r <= 1'b0;
            defer_ovf_r   <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            guard_cnt_r   <= guard_next_s;
            wait_cnt_r    <= wait_next_s;
            // Registered from the next state so it tracks state_r exactly.
            secure_busy_r <= (state_next_s != ST_OPEN);
            defer_ovf_r   <= defer_ovf_r || (wait_cnt_r == MAX_DEFER);
        end
    end

    assign secure_busy = secure_busy_r;
    assign defer_ovf   = defer_ovf_r;

`ifdef IRQ_DEFER_EN
    logic irq_pend_r;

    // Pending latch for IRQs arriving while masked; a new masked IRQ wins over ack.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irq_pend_r <= 1'b0;
        end else if (irq_in && !open_s) begin
            irq_pend_r <= 1'b1;
        end else if (irq_ack) begin
            irq_pend_r <= 1'b0;
        end else begin
            irq_pend_r <= irq_pend_r;
        end
    end

    assign irq_out = open_s && (irq_in || irq_pend_r);
`else
    logic unused_irq_ack_s;
    assign unused_irq_ack_s = irq_ack;
    assign irq_out = irq_in && open_s;
`endif

endmodule

// File: tb/tb_smem_dma_scheduler.sv
// Directed self-checking bench for smem_dma_scheduler (default parameters:
// SMEM 0xA000..0xDFFE, EXIT_GUARD=4, MAX_DEFER=1024). Inputs change 1ns
// after the rising edge; outputs are sampled on the falling edge.
module tb_smem_dma_scheduler;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] pc;
    logic        dma_req;
    logic        dma_grant;
    logic        irq_in;
    logic        irq_ack;
    logic        irq_out;
    logic        secure_busy;
    logic        defer_ovf;

    int total = 0;
    int bad   = 0;

    smem_dma_scheduler dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pc          (pc),
        .dma_req     (dma_req),
        .dma_grant   (dma_grant),
        .irq_in      (irq_in),
        .irq_ack     (irq_ack),
        .irq_out     (irq_out),
        .secure_busy (secure_busy),
        .defer_ovf   (defer_ovf)
    );

    always #5 clk = ~clk;

    // One clock cycle: drive inputs after the edge, return at mid-cycle.
    task automatic cyc(input logic rst_v, input logic [15:0] pc_v,
                       input logic req_v, input logic irq_v, input logic ack_v);
        @(posedge clk);
        #1;
        reset_n = rst_v;
        pc      = pc_v;
        dma_req = req_v;
        irq_in  = irq_v;
        irq_ack = ack_v;
        @(negedge clk);
    endtask

    task automatic test_reset();
        cyc(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        total++; if (secure_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", secure_busy); end
        total++; if (defer_ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", defer_ovf); end
        cyc(1'b1, 16'h4000, 1'b1, 1'b0, 1'b0);
        total++; if (dma_grant !== 1'b1) begin bad++; $display("FAIL open_grant got=%b exp=1", dma_grant); end
        total++; if (secure_busy !== 1'b0) begin bad++; $display("FAIL open_busy got=%b exp=0", secure_busy); end
    endtask

    task automatic test_entry();
        cyc(1'b1, 16'h9FFE, 1'b1, 1'b0, 1'b0);
        total++; if (dma_grant !== 1'b1) begin bad++; $display("FAIL below_base_grant got=%b exp=1", dma_grant); end
        cyc(1'b1, 16'hA000, 1'b1, 1'b0, 1'b0);
        total++; if (dma_grant !== 1'b0) begin bad++; $display("FAIL entry_grant got=%b exp=0", dma_grant); end
        total++; if (secure_busy !== 1'b0) begin bad++; $display("FAIL entry_busy got=%b exp=0", secure_busy); end
        cyc(1'b1, 16'hDFFE, 1'b1, 1'b0, 1'b0);
        total++; if (secure_busy !== 1'b1) begin bad++; $display("FAIL secure_busy got=%b exp=1", secure_busy); end
        total++; if (dma_grant !== 1'b0) begin bad++; $display("FAIL last_word_grant got=%b exp=0", dma_grant); end
    endtask

    // From SECURE, leave SMEM: 5 denied cycles, then grant.
    task automatic test_exit_guard();
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 16'h5000, 1'b1, 1'b0, 1'b0);
            total++; if (dma_grant !== 1'b0) begin bad++; $display("FAIL guard_grant[%0d] got=%b exp=0", i, dma_grant); end
        end
        total++; if (secure_busy !== 1'b1) begin bad++; $display("FAIL guard_busy got=%b exp=1", secure_busy); end
        cyc(1'b1, 16'h5000, 1'b1, 1'b0, 1'b0);
        total++; if (dma_grant !== 1'b1) begin bad++; $display("FAIL regrant got=%b exp=1", dma_grant); end
        total++; if (secure_busy !== 1'b0) begin bad++; $display("FAIL regrant_busy got=%b exp=0", secure_busy); end
    endtask

    task automatic test_reentry();
        cyc(1'b1, 16'hA000, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 16'h5000, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 16'h5000, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 16'hB000, 1'b1, 1'b0, 1'b0);
        total++; if (dma_grant !== 1'b0) begin bad++; $display("FAIL reentry_grant got=%b exp=0", dma_grant); end
        cyc(1'b1, 16'hB000, 1'b1, 1'b0, 1'b0);
        total++; if (secure_busy !== 1'b1) begin bad++; $display("FAIL reentry_busy got=%b exp=1", secure_busy); end
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 16'h5000, 1'b1, 1'b0, 1'b0);
            total++; if (dma_grant !== 1'b0) begin bad++; $display("FAIL rewindow_grant[%0d] got=%b exp=0", i, dma_grant); end
        end
        cyc(1'b1, 16'h5000, 1'b1, 1'b0, 1'b0);
        total++; if (dma_grant !== 1'b1) begin bad++; $display("FAIL rewindow_regrant got=%b exp=1", dma_grant); end
    endtask

    // wait_cnt reaches 1024 during the 1025th denied cycle; flag visible from the 1026th.
    task automatic test_defer_ovf();
        for (int i = 0; i < 1020; i++) cyc(1'b1, 16'hA000, 1'b1, 1'b0, 1'b0);
        total++; if (defer_ovf !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b exp=0", defer_ovf); end
        for (int i = 0; i < 80; i++) cyc(1'b1, 16'hA000, 1'b1, 1'b0, 1'b0);
        total++; if (defer_ovf !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", defer_ovf); end
        for (int i = 0; i < 6; i++) cyc(1'b1, 16'h5000, 1'b1, 1'b0, 1'b0);
        total++; if (dma_grant !== 1'b1) begin bad++; $display("FAIL ovf_regrant got=%b exp=1", dma_grant); end
        total++; if (defer_ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", defer_ovf); end
        cyc(1'b1, 16'hA000, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        total++; if (defer_ovf !== 1'b0) begin bad++; $display("FAIL ovf_reset got=%b exp=0", defer_ovf); end
        total++; if (secure_busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b exp=0", secure_busy); end
    endtask

    task automatic test_irq();
        logic exp_def;
`ifdef IRQ_DEFER_EN
        exp_def = 1'b1;
`else
        exp_def = 1'b0;
`endif
        cyc(1'b1, 16'h4000, 1'b0, 1'b1, 1'b0);
        total++; if (irq_out !== 1'b1) begin bad++; $display("FAIL irq_open got=%b exp=1", irq_out); end
        cyc(1'b1, 16'hA000, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'hA010, 1'b0, 1'b1, 1'b0);
        total++; if (irq_out !== 1'b0) begin bad++; $display("FAIL irq_masked got=%b exp=0", irq_out); end
        cyc(1'b1, 16'hA010, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 16'h5000, 1'b0, 1'b0, 1'b0);
            total++; if (irq_out !== 1'b0) begin bad++; $display("FAIL irq_guard[%0d] got=%b exp=0", i, irq_out); end
        end
        cyc(1'b1, 16'h5000, 1'b0, 1'b0, 1'b0);
        total++; if (irq_out !== exp_def) begin bad++; $display("FAIL irq_first_open got=%b exp=%b", irq_out, exp_def); end
        cyc(1'b1, 16'h5000, 1'b0, 1'b0, 1'b0);
        total++; if (irq_out !== exp_def) begin bad++; $display("FAIL irq_held got=%b exp=%b", irq_out, exp_def); end
        cyc(1'b1, 16'h5000, 1'b0, 1'b0, 1'b1);
        total++; if (irq_out !== exp_def) begin bad++; $display("FAIL irq_ack_cycle got=%b exp=%b", irq_out, exp_def); end
        cyc(1'b1, 16'h5000, 1'b0, 1'b0, 1'b0);
        total++; if (irq_out !== 1'b0) begin bad++; $display("FAIL irq_cleared got=%b exp=0", irq_out); end
    endtask

    initial begin
        reset_n = 1'b0;
        pc      = 16'h0000;
        dma_req = 1'b0;
        irq_in  = 1'b0;
        irq_ack = 1'b0;
        test_reset();
        test_entry();
        test_exit_guard();
        test_reentry();
        test_defer_ovf();
        test_irq();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
